// File: rtl/t_param_pkg.sv
// Shared definitions for the round-robin counter emitter: mode codes,
// FSM state encoding and the channel-index width helper.
package t_param_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int chw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/t_param_chan_ctr.sv
// One (WIDTH+1)-bit channel counter: loads INIT on reset/clear and
// advances by STEP on inc, either wrapping or saturating at all-ones.
module t_param_chan_ctr
  import t_param_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int INIT  = 5,
  parameter int STEP  = 2,
  parameter int MODE  = MODE_WRAP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [WIDTH:0] cnt
);

  localparam int CW = WIDTH + 1;
  localparam logic [WIDTH:0] INIT_V = CW'(INIT);
  localparam logic [WIDTH:0] STEP_V = CW'(STEP);

  // The sum is formed one bit wider so the carry marks overflow for saturation.
  function automatic logic [WIDTH:0] advance(input logic [WIDTH:0] v);
    logic [WIDTH+1:0] sum;
    sum = {1'b0, v} + {1'b0, STEP_V};
    if ((MODE == MODE_SAT) && sum[WIDTH+1])
      return '1;
    return sum[WIDTH:0];
  endfunction

  // Counter register: clear outranks an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= INIT_V;
    else if (clr)
      cnt <= INIT_V;
    else if (inc)
      cnt <= advance(cnt);
  end

endmodule

// File: rtl/t_param_chan.sv
// Multi-channel round-robin counter emitter. One channel at a time is
// offered on a valid/ready output; each accepted item advances that
// channel's counter, moves the pointer on and bumps the transfer tally.
module t_param_chan
  import t_param_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int INIT     = 5,
  parameter int STEP     = 2,
  parameter int MODE     = MODE_WRAP,
  parameter int PAR_W    = 5,
  localparam int CHW     = chw_of(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CHW-1:0]   chan,
  output logic [WIDTH:0]   varwidth,
  output logic [PAR_W-1:0] par
);

  state_t                state;
  state_t                state_nxt;
  logic                  xfer;
  logic [CHW-1:0]        ptr;
  logic [PAR_W-1:0]      tally;
  logic [CHANNELS-1:0]   inc;
  logic [WIDTH:0]        cnt_a [CHANNELS];

  function automatic logic [CHW-1:0] ptr_next(input logic [CHW-1:0] p);
    return (p == CHW'(CHANNELS - 1)) ? '0 : p + CHW'(1);
  endfunction

  // Next-state logic: an offered item is held until accepted; clear wins over everything.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en)
          state_nxt = ST_VALID;
      end
      ST_VALID: begin
        if (out_ready) begin
          xfer      = 1'b1;
          state_nxt = en ? ST_VALID : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clr) begin
      xfer      = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  // Per-channel increment strobe: only the channel under the pointer moves.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      inc[c] = xfer && (ptr == CHW'(c));
  end

  // Control registers: FSM state, round-robin pointer and transfer tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
      tally <= '0;
    end else if (clr) begin
      state <= ST_IDLE;
      ptr   <= '0;
      tally <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        ptr   <= ptr_next(ptr);
        tally <= tally + PAR_W'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ctr
    t_param_chan_ctr #(
      .WIDTH (WIDTH),
      .INIT  (INIT),
      .STEP  (STEP),
      .MODE  (MODE)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[c]),
      .cnt   (cnt_a[c])
    );
  end

  // Output mux: present the counter of the channel under the pointer.
  always_comb begin
    varwidth = cnt_a[0];
    for (int c = 0; c < CHANNELS; c++)
      if (ptr == CHW'(c))
        varwidth = cnt_a[c];
  end

  assign out_valid = (state == ST_VALID);
  assign chan      = ptr;
  assign par       = tally;

endmodule
